aes_cbc_ctrl: RTL and testbench

Initiator-side controller that drives the AES core's START/DONE handshake. It accepts a stream of 128-bit blocks over valid/ready and issues one core operation per block. It applies CBC chaining (or ECB when disabled) and returns results over a valid/ready output. It sits between a block source/sink (DMA or bus wrapper) and aes_top, and owns chaining state and the DONE watchdog.

---
 rtl/aes_ctrl_pkg.sv | 19 +
 rtl/aes_cbc_ctrl_if.sv | 30 +++
 rtl/aes_watchdog.sv | 34 +++
 rtl/aes_cbc_ctrl.sv | 130 +++++++++++++
 tb/tb_aes_cbc_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES block-chaining controller.
package aes_ctrl_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        ERR   = 3'd4
    } state_e;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

endpackage

// File: rtl/aes_cbc_ctrl_if.sv
// Block stream interface between a source/sink (DMA, bus wrapper) and the controller.
interface aes_cbc_ctrl_if;
    import aes_ctrl_pkg::*;

    logic   ENCDEC_IN;
    block_t KEY_IN;
    block_t IV;
    logic   LOAD_IV;
    logic   IN_VALID;
    logic   IN_READY;
    block_t IN_DATA;
    logic   IN_LAST;
    logic   OUT_VALID;
    logic   OUT_READY;
    block_t OUT_DATA;
    logic   OUT_LAST;
    logic   BUSY;
    logic   ERR_TIMEOUT;

    modport master (
        output ENCDEC_IN, KEY_IN, IV, LOAD_IV, IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, BUSY, ERR_TIMEOUT
    );

    modport slave (
        input  ENCDEC_IN, KEY_IN, IV, LOAD_IV, IN_VALID, IN_DATA, IN_LAST, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, BUSY, ERR_TIMEOUT
    );

endinterface

// File: rtl/aes_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags when the count is about to reach limit-1.
module aes_watchdog (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [9:0] limit,
    output logic       expired
);

    logic [9:0] count_q;
    logic [9:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 10'd1;
        end
    end

    // Flags on the cycle the counter would step onto limit-1, so the caller leaves WAIT at that edge.
    assign expired = enable && !clear && (count_d == limit - 10'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aes_cbc_ctrl.sv
// AES core initiator: one START/DONE operation per streamed block, with CBC or ECB chaining.
module aes_cbc_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter bit          CHAIN_EN       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic           CLK,
    input  logic           RST,
    aes_cbc_ctrl_if.slave  io,
    output logic           CORE_START,
    output logic           CORE_ENCDEC,
    output block_t         CORE_KEY,
    output block_t         CORE_TEXTIN,
    input  logic           CORE_DONE,
    input  block_t         CORE_TEXTOUT
);

    state_e state_q, state_d;
    logic   armed_q;
    block_t chain_q, chain_d;
    block_t text_q, text_d;
    block_t cipher_q, cipher_d;
    block_t out_q, out_d;
    block_t key_q, key_d;
    logic   encdec_q, encdec_d;
    logic   last_q, last_d;
    block_t chain_eff;
    logic   accept;
    logic   wd_clear, wd_enable, wd_expired;

    assign wd_clear  = (state_q == ISSUE);
    assign wd_enable = (state_q == WAIT);

    aes_watchdog u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (10'(TIMEOUT_CYCLES)),
        .expired (wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        chain_d  = chain_q;
        text_d   = text_q;
        cipher_d = cipher_q;
        out_d    = out_q;
        key_d    = key_q;
        encdec_d = encdec_q;
        last_d   = last_q;
        // A same-cycle IV load must feed the block being accepted.
        chain_eff = io.LOAD_IV ? io.IV : chain_q;
        accept    = (state_q == IDLE) && armed_q && io.IN_VALID;

        unique case (state_q)
            IDLE: begin
                if (io.LOAD_IV) chain_d = io.IV;
                if (accept) begin
                    key_d    = io.KEY_IN;
                    encdec_d = io.ENCDEC_IN;
                    last_d   = io.IN_LAST;
                    text_d   = (io.ENCDEC_IN == ENC && CHAIN_EN) ? (io.IN_DATA ^ chain_eff) : io.IN_DATA;
                    if (io.ENCDEC_IN == DEC) cipher_d = io.IN_DATA;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (CORE_DONE) begin
                    if (encdec_q == ENC) begin
                        out_d   = CORE_TEXTOUT;
                        chain_d = CORE_TEXTOUT;
                    end else begin
                        out_d   = CHAIN_EN ? (CORE_TEXTOUT ^ chain_q) : CORE_TEXTOUT;
                        chain_d = cipher_q;
                    end
                    state_d = OUT;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            OUT: begin
                if (io.OUT_READY) begin
                    if (last_q) chain_d = io.IV;
                    state_d = IDLE;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            armed_q  <= 1'b0;
            chain_q  <= '0;
            text_q   <= '0;
            cipher_q <= '0;
            out_q    <= '0;
            key_q    <= '0;
            encdec_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= 1'b1;
            chain_q  <= chain_d;
            text_q   <= text_d;
            cipher_q <= cipher_d;
            out_q    <= out_d;
            key_q    <= key_d;
            encdec_q <= encdec_d;
            last_q   <= last_d;
        end
    end

    assign io.IN_READY    = armed_q && (state_q == IDLE);
    assign io.OUT_VALID   = (state_q == OUT);
    assign io.OUT_DATA    = out_q;
    assign io.OUT_LAST    = last_q;
    assign io.BUSY        = (state_q != IDLE);
    assign io.ERR_TIMEOUT = (state_q == ERR);
    assign CORE_START     = (state_q == ISSUE);
    assign CORE_ENCDEC    = encdec_q;
    assign CORE_KEY       = key_q;
    assign CORE_TEXTIN    = text_q;

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Directed bench: an ECB instance and a CBC instance (16-cycle timeout) driven from one stream.
module tb_aes_cbc_ctrl;
    import aes_ctrl_pkg::*;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic         sel_e = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b0, load_iv = 1'b0, encdec = 1'b0, in_last = 1'b0;
    logic [127:0] in_data = '0, key = '0, iv = IV0;
    logic         suppress_c = 1'b0, inj_c = 1'b0;

    aes_cbc_ctrl_if bus_e ();
    aes_cbc_ctrl_if bus_c ();

    assign bus_e.ENCDEC_IN = encdec;   assign bus_c.ENCDEC_IN = encdec;
    assign bus_e.KEY_IN    = key;      assign bus_c.KEY_IN    = key;
    assign bus_e.IV        = iv;       assign bus_c.IV        = iv;
    assign bus_e.LOAD_IV   = load_iv;  assign bus_c.LOAD_IV   = load_iv;
    assign bus_e.IN_DATA   = in_data;  assign bus_c.IN_DATA   = in_data;
    assign bus_e.IN_LAST   = in_last;  assign bus_c.IN_LAST   = in_last;
    assign bus_e.IN_VALID  = in_valid & sel_e;
    assign bus_c.IN_VALID  = in_valid & ~sel_e;
    assign bus_e.OUT_READY = out_ready & sel_e;
    assign bus_c.OUT_READY = out_ready & ~sel_e;

    // Core-side nets for each instance.
    logic         ce_start, ce_encdec, ce_done = 1'b0;
    logic [127:0] ce_key, ce_textin, ce_res = '0;
    logic [2:0]   ce_cnt = '0;
    logic         cc_start, cc_encdec, cc_done, cc_done_m = 1'b0;
    logic [127:0] cc_key, cc_textin, cc_res = '0;
    logic [2:0]   cc_cnt = '0;
    assign cc_done = cc_done_m | inj_c;

    aes_cbc_ctrl #(.CHAIN_EN(1'b0), .TIMEOUT_CYCLES(64)) u_ecb (
        .CLK(clk), .RST(rst), .io(bus_e),
        .CORE_START(ce_start), .CORE_ENCDEC(ce_encdec), .CORE_KEY(ce_key),
        .CORE_TEXTIN(ce_textin), .CORE_DONE(ce_done), .CORE_TEXTOUT(ce_res)
    );

    aes_cbc_ctrl #(.CHAIN_EN(1'b1), .TIMEOUT_CYCLES(16)) u_cbc (
        .CLK(clk), .RST(rst), .io(bus_c),
        .CORE_START(cc_start), .CORE_ENCDEC(cc_encdec), .CORE_KEY(cc_key),
        .CORE_TEXTIN(cc_textin), .CORE_DONE(cc_done), .CORE_TEXTOUT(cc_res)
    );

    // Core stand-in: known FIPS-197 / SP800-38A block pairs as seen at the core boundary.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic dec, input logic [127:0] t);
        logic [127:0] ky [3];
        logic [127:0] pt [3];
        logic [127:0] ct [3];
        ky = '{K1, K2, K2};
        pt = '{PT0, P1 ^ IV0, P2 ^ C1};
        ct = '{CT0, C1, C2};
        core_fn = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        for (int i = 0; i < 3; i++) begin
            if (k == ky[i] && !dec && t == pt[i]) core_fn = ct[i];
            if (k == ky[i] && dec && t == ct[i])  core_fn = pt[i];
        end
    endfunction

    always @(posedge clk) begin
        ce_done <= 1'b0;
        if (ce_start) begin
            ce_cnt <= 3'd3;
            ce_res <= core_fn(ce_key, ce_encdec, ce_textin);
        end else if (ce_cnt != 3'd0) begin
            ce_cnt  <= ce_cnt - 3'd1;
            ce_done <= (ce_cnt == 3'd1);
        end
    end

    always @(posedge clk) begin
        cc_done_m <= 1'b0;
        if (cc_start && !suppress_c) begin
            cc_cnt <= 3'd3;
            cc_res <= core_fn(cc_key, cc_encdec, cc_textin);
        end else if (cc_cnt != 3'd0) begin
            cc_cnt    <= cc_cnt - 3'd1;
            cc_done_m <= (cc_cnt == 3'd1);
        end
    end

    logic         r_in_ready, r_out_valid, r_out_last, r_busy, r_err, r_core_start;
    logic [127:0] r_out_data, r_core_textin;
    assign r_in_ready    = sel_e ? bus_e.IN_READY    : bus_c.IN_READY;
    assign r_out_valid   = sel_e ? bus_e.OUT_VALID   : bus_c.OUT_VALID;
    assign r_out_last    = sel_e ? bus_e.OUT_LAST    : bus_c.OUT_LAST;
    assign r_out_data    = sel_e ? bus_e.OUT_DATA    : bus_c.OUT_DATA;
    assign r_busy        = sel_e ? bus_e.BUSY        : bus_c.BUSY;
    assign r_err         = sel_e ? bus_e.ERR_TIMEOUT : bus_c.ERR_TIMEOUT;
    assign r_core_start  = sel_e ? ce_start          : cc_start;
    assign r_core_textin = sel_e ? ce_textin         : cc_textin;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic last, input logic dec,
                        input logic [127:0] k, input logic liv);
        int n = 0;
        in_data = d; in_last = last; encdec = dec; key = k; load_iv = liv; in_valid = 1'b1;
        while (!r_in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk1("send_ready", r_in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        load_iv  = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [127:0] exp, input logic exp_last);
        int n = 0;
        while (!r_out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_valid"}, r_out_valid, 1'b1);
        chk(tag, r_out_data, exp);
        chk1({tag, "_last"}, r_out_last, exp_last);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1({tag, "_idle"}, r_busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk1("rst_in_ready", r_in_ready, 1'b0);
        chk1("rst_busy", r_busy, 1'b0);
        chk1("rst_out_valid", r_out_valid, 1'b0);
        chk1("rst_err", r_err, 1'b0);
        chk1("rst_core_start", r_core_start, 1'b0);
        chk("rst_out_data", r_out_data, '0);
        rst = 1'b0;
        @(negedge clk);
        chk1("in_ready_after_rst", r_in_ready, 1'b1);

        // ECB encrypt/decrypt
        send(PT0, 1'b0, ENC, K1, 1'b0);
        chk1("ecb_start", r_core_start, 1'b1);
        chk("ecb_textin", r_core_textin, PT0);
        @(negedge clk);
        chk1("ecb_start_pulse", r_core_start, 1'b0);
        recv("ecb_enc", CT0, 1'b0);
        send(CT0, 1'b0, DEC, K1, 1'b0);
        recv("ecb_dec", PT0, 1'b0);

        // CBC encrypt, two-block message
        sel_e = 1'b0;
        load_iv = 1'b1;
        @(negedge clk);
        load_iv = 1'b0;
        send(P1, 1'b0, ENC, K2, 1'b0);
        recv("cbc_enc1", C1, 1'b0);
        send(P2, 1'b1, ENC, K2, 1'b0);
        recv("cbc_enc2", C2, 1'b1);

        // CBC decrypt, then a one-block message relying on re-arm
        load_iv = 1'b1;
        @(negedge clk);
        load_iv = 1'b0;
        send(C1, 1'b0, DEC, K2, 1'b0);
        recv("cbc_dec1", P1, 1'b0);
        send(C2, 1'b1, DEC, K2, 1'b0);
        recv("cbc_dec2", P2, 1'b1);
        send(C1, 1'b1, DEC, K2, 1'b0);
        recv("cbc_rearm", P1, 1'b1);

        // Output backpressure
        send(P1, 1'b1, ENC, K2, 1'b0);
        while (!r_out_valid && n_cmp < 100000) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk1("bp_valid", r_out_valid, 1'b1);
            chk("bp_data", r_out_data, C1);
            chk1("bp_in_ready", r_in_ready, 1'b0);
            chk1("bp_busy", r_busy, 1'b1);
            @(negedge clk);
        end
        recv("bp_out", C1, 1'b1);

        // LOAD_IV coinciding with accept while chain holds C1
        send(P1, 1'b0, ENC, K2, 1'b0);
        recv("pre_liv", C1, 1'b0);
        send(P1, 1'b1, ENC, K2, 1'b1);
        chk("liv_textin", r_core_textin, P1 ^ IV0);
        recv("liv_out", C1, 1'b1);

        // Reset during WAIT abandons the block
        send(P1, 1'b1, ENC, K2, 1'b0);
        @(negedge clk);
        chk1("wait_busy", r_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("rstwait_busy", r_busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1("rstwait_no_out", r_out_valid, 1'b0);
            chk1("rstwait_idle", r_busy, 1'b0);
        end

        // Core timeout
        suppress_c = 1'b1;
        send(P1, 1'b1, ENC, K2, 1'b1);
        chk1("to_start", r_core_start, 1'b1);
        repeat (15) @(negedge clk);
        chk1("to_err_early", r_err, 1'b0);
        @(negedge clk);
        chk1("to_err", r_err, 1'b1);
        chk1("to_in_ready", r_in_ready, 1'b0);
        chk1("to_out_valid", r_out_valid, 1'b0);
        inj_c = 1'b1;
        @(negedge clk);
        inj_c = 1'b0;
        repeat (3) @(negedge clk);
        chk1("late_done_err", r_err, 1'b1);
        chk1("late_done_no_out", r_out_valid, 1'b0);
        chk1("late_done_busy", r_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        suppress_c = 1'b0;
        chk1("to_rst_err", r_err, 1'b0);
        chk1("to_rst_busy", r_busy, 1'b0);
        @(negedge clk);
        chk1("to_rst_ready", r_in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
